sram_unit_access_ctrl: RTL and testbench
========================================

// Module: sram_unit_access_ctrl
// PURPOSE
//  Sub-word access controller feeding SRAM_unit_input_shifter and one 8-bit-wide SRAM macro.
//  Accepts one 1/2/4/8-bit read/write request at a time (valid/ready).
//  Drives shifter width selects + right-justified data, SRAM enable/we/addr/bit-mask.
//  Extracts and right-justifies read sub-words; returns a response (valid/ready).
// PARAMETERS
//  ADDR_W  8  SRAM word-address width
//  RD_LAT  1  SRAM read latency in cycles, sram_en to sram_dout valid (range 1..7)
// PORTS
//  clk        in   1       single clock; all state on posedge
//  rst_n      in   1       asynchronous active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       controller can accept; high only in IDLE
//  req_we     in   1       1=write, 0=read
//  req_size   in   2       0=1b, 1=2b, 2=4b, 3=8b
//  req_addr   in   ADDR_W  SRAM word address
//  req_off    in   3       bit offset of sub-word within word
//  req_wdata  in   8       write data, right-justified; bits >= width ignored
//  sh_d_in    out  8       to shifter d_in: registered req_wdata
//  sh_c8/c4/c2/c1 out 1 each  to shifter: one-hot width select; all 0 outside ISSUE
//  sram_en    out  1       SRAM access strobe, one cycle per access
//  sram_we    out  1       SRAM write enable (qualified by sram_en)
//  sram_addr  out  ADDR_W  SRAM word address
//  sram_wmask out  8       per-bit write mask; shifter output d_sram is the data
//  sram_dout  in   8       SRAM read data, valid RD_LAT cycles after read strobe
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       response consumed
//  rsp_data   out  8       read data, right-justified, zero-extended; 0 for writes
//  rsp_err    out  1       request rejected (SRAM_ACC_ERR_EN only), else 0
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; rsp_valid=0; sram_en=0; sram_we=0; sram_wmask=0;
//   sram_addr=0; sh_d_in=0; sh_c*=0; rsp_data=0; rsp_err=0; latency counter=0.
//  FSM IDLE -> ISSUE -> (read: WAIT) -> RESP -> IDLE. One request outstanding.
//  IDLE: req_valid&req_ready latches we/size/addr/off/wdata -> ISSUE next cycle.
//  ISSUE (1 cycle): sram_en=1, sram_we=we, c-select one-hot from size;
//   mask n=2^size bits at [off+n-1:off], wmask=0 on reads. Write -> RESP; read -> WAIT.
//  WAIT: counter runs RD_LAT cycles from the ISSUE edge; on the RD_LAT-th edge capture
//   rsp_data = (sram_dout>>off) & ((1<<n)-1) -> RESP. Min read latency req->rsp_valid = 2+RD_LAT.
//  RESP: rsp_valid=1, data/err stable until rsp_ready; rsp_valid&rsp_ready -> IDLE.
//   Write ack appears 2 cycles after acceptance. No same-cycle re-accept; next req_ready in IDLE.
//  Offset alignment: off must be a multiple of n. size=3 forces off=0 in all builds.
//  rst_n low mid-operation: abort immediately to reset values; the current SRAM strobe is
//   dropped asynchronously; a pending read result is discarded.
// CONFIGURATION
//  SRAM_ACC_ERR_EN defined: misaligned off (off%n!=0) skips ISSUE/WAIT.
//   It goes IDLE -> RESP with rsp_err=1, rsp_data=0 and no SRAM strobe.
//  Undefined: low log2(n) bits of off cleared (aligned down); access proceeds; rsp_err tied 0.
// STRUCTURE
//  Shared header sram_unit_defs.vh: size codes SZ_1/SZ_2/SZ_4/SZ_8, FSM state encodings
//   (IDLE/ISSUE/WAIT/RESP, 2 bits), shifter select-vector ordering {c8,c4,c2,c1}.
//  Sub-module sram_unit_lane_mask (combinational): size,off -> one-hot selects, aligned off,
//   8-bit mask, misalign flag. Also reused by the read-side extractor.
// TESTING
//  1. Write size=0 addr=5 off=6 wdata=1 -> ISSUE: c1=1, sh_d_in[0]=1, sram_wmask=8'h40,
//     sram_addr=5, sram_we=1; rsp_valid 2 cycles after accept, rsp_err=0.
//  2. Read size=2 off=4, RD_LAT=1, sram_dout=8'hA5 -> rsp_data=8'h0A, rsp_valid at cycle 3.
//  3. Read size=1 off=2, sram_dout=8'b0000_1100, hold rsp_ready=0 for 4 cycles
//     -> rsp_data=8'h03 stable, req_ready=0 throughout.
//  4. size=2 off=2: ERR_EN -> rsp_err=1, sram_en never 1; else wmask=8'h0F.
//  5. Assert rst_n low during WAIT of a read -> all outputs to reset values same cycle;
//     after release req_ready=1, no stale rsp_valid.
//  6. Back-to-back 8 writes size=3 with rsp_ready=1 -> one acceptance per 3 cycles,
//     wmask=8'hFF, c8=1 each ISSUE.

Source files
------------

// File: rtl/sram_unit_access_ctrl_pkg.sv
// Shared definitions for the SRAM sub-word access controller: size codes, FSM states,
// shifter select ordering. Optional build macro: SRAM_ACC_ERR_EN (misaligned requests rejected).
package sram_unit_access_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_1 = 2'd0,
    SZ_2 = 2'd1,
    SZ_4 = 2'd2,
    SZ_8 = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Shifter select vector is packed {c8,c4,c2,c1}
  localparam int unsigned SEL_C1 = 0;
  localparam int unsigned SEL_C2 = 1;
  localparam int unsigned SEL_C4 = 2;
  localparam int unsigned SEL_C8 = 3;

`ifdef SRAM_ACC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  function automatic logic [7:0] width_mask(input size_e size);
    case (size)
      SZ_1:    return 8'h01;
      SZ_2:    return 8'h03;
      SZ_4:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Offset bits that survive alignment to the access width
  function automatic logic [2:0] align_keep(input size_e size);
    case (size)
      SZ_1:    return 3'b111;
      SZ_2:    return 3'b110;
      SZ_4:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sram_unit_access_ctrl_lane_mask.sv
// Combinational lane decoder: size/offset -> one-hot shifter selects, aligned offset,
// 8-bit lane mask and misalignment flag.
module sram_unit_lane_mask
  import sram_unit_access_ctrl_pkg::*;
(
  input  logic [1:0] size,
  input  logic [2:0] off,
  output logic [3:0] sel,
  output logic [2:0] off_al,
  output logic [7:0] mask,
  output logic       misalign
);

  size_e sz;

  always_comb begin
    sz       = size_e'(size);
    sel      = 4'b0001 << size;
    off_al   = off & align_keep(sz);
    mask     = width_mask(sz) << off_al;
    // A full-word access ignores the offset entirely, so it is never misaligned
    misalign = (sz != SZ_8) && ((off & ~align_keep(sz)) != 3'b000);
  end

endmodule

// File: rtl/sram_unit_access_ctrl.sv
// Sub-word read/write controller in front of an 8-bit SRAM macro and its input shifter.
// Optional build macro: SRAM_ACC_ERR_EN (misaligned requests answered with rsp_err, no access).
module sram_unit_access_ctrl
  import sram_unit_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_off,
  input  logic [7:0]        req_wdata,
  output logic [7:0]        sh_d_in,
  output logic              sh_c8,
  output logic              sh_c4,
  output logic              sh_c2,
  output logic              sh_c1,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wmask,
  input  logic [7:0]        sram_dout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              rsp_err
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_e     state;
  logic       we_q;
  size_e      size_q;
  logic [2:0] off_q;
  logic [2:0] lat_cnt;
  logic [3:0] sh_sel;

  logic [3:0] lm_sel;
  logic [2:0] lm_off_al;
  logic [7:0] lm_mask;
  logic       lm_misalign;

  sram_unit_lane_mask u_lane_mask (
    .size     (req_size),
    .off      (req_off),
    .sel      (lm_sel),
    .off_al   (lm_off_al),
    .mask     (lm_mask),
    .misalign (lm_misalign)
  );

  assign sh_c8 = sh_sel[SEL_C8];
  assign sh_c4 = sh_sel[SEL_C4];
  assign sh_c2 = sh_sel[SEL_C2];
  assign sh_c1 = sh_sel[SEL_C1];

  // SRAM strobe and shifter selects are loaded on the accept edge so they are
  // registered outputs valid exactly for the ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wmask <= '0;
      sh_d_in    <= '0;
      sh_sel     <= '0;
      we_q       <= 1'b0;
      size_q     <= SZ_1;
      off_q      <= '0;
      lat_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            size_q    <= size_e'(req_size);
            off_q     <= lm_off_al;
            sram_addr <= req_addr;
            sh_d_in   <= req_wdata;
            rsp_data  <= '0;
            if (ERR_EN && lm_misalign) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
            end else begin
              state      <= ST_ISSUE;
              sram_en    <= 1'b1;
              sram_we    <= req_we;
              sram_wmask <= req_we ? lm_mask : 8'h00;
              sh_sel     <= lm_sel;
            end
          end
        end
        ST_ISSUE: begin
          sram_en    <= 1'b0;
          sram_we    <= 1'b0;
          sram_wmask <= '0;
          sh_sel     <= '0;
          if (we_q) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
          end else begin
            state   <= ST_WAIT;
            lat_cnt <= 3'd1;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == LAT) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= (sram_dout >> off_q) & width_mask(size_q);
            lat_cnt   <= '0;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SRAM_ACC_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (state == ST_IDLE && req_valid)
      err_q <= lm_misalign;
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_unit_access_ctrl.sv
// Directed bench for sram_unit_access_ctrl with RD_LAT=1; expectations hand-computed.
module tb_sram_unit_access_ctrl;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_off;
  logic [7:0]        req_wdata;
  logic [7:0]        sh_d_in;
  logic              sh_c8, sh_c4, sh_c2, sh_c1;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_wmask;
  logic [7:0]        sram_dout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_data;
  logic              rsp_err;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  sram_unit_access_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_off    (req_off),
    .req_wdata  (req_wdata),
    .sh_d_in    (sh_d_in),
    .sh_c8      (sh_c8),
    .sh_c4      (sh_c4),
    .sh_c2      (sh_c2),
    .sh_c1      (sh_c1),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_dout  (sram_dout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic [7:0] addr,
                           input logic [2:0] off, input logic [7:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_off   = off;
    req_wdata = wdata;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"},  32'(req_ready),  32'h1);
    check({tag, ".rsp_valid"},  32'(rsp_valid),  32'h0);
    check({tag, ".sram_en"},    32'(sram_en),    32'h0);
    check({tag, ".sram_we"},    32'(sram_we),    32'h0);
    check({tag, ".sram_wmask"}, 32'(sram_wmask), 32'h0);
    check({tag, ".sram_addr"},  32'(sram_addr),  32'h0);
    check({tag, ".sh_d_in"},    32'(sh_d_in),    32'h0);
    check({tag, ".sh_sel"},     32'({sh_c8, sh_c4, sh_c2, sh_c1}), 32'h0);
    check({tag, ".rsp_data"},   32'(rsp_data),   32'h0);
    check({tag, ".rsp_err"},    32'(rsp_err),    32'h0);
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, ".idle_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, ".idle_req_ready"}, 32'(req_ready), 32'h1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'd0;
    req_addr  = '0;
    req_off   = 3'd0;
    req_wdata = 8'h00;
    rsp_ready = 1'b0;
    sram_dout = 8'h00;

    // Reset state
    tick();
    tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // 1: 1-bit write at offset 6
    drive_req(1'b1, 2'd0, 8'd5, 3'd6, 8'h01);
    check("t1.req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 1'b0;
    check("t1.sram_en",    32'(sram_en),    32'h1);
    check("t1.sram_we",    32'(sram_we),    32'h1);
    check("t1.sel",        32'({sh_c8, sh_c4, sh_c2, sh_c1}), 32'h1);
    check("t1.sh_d_in",    32'(sh_d_in),    32'h01);
    check("t1.sram_wmask", 32'(sram_wmask), 32'h40);
    check("t1.sram_addr",  32'(sram_addr),  32'h05);
    check("t1.rsp_valid0", 32'(rsp_valid),  32'h0);
    tick();
    check("t1.rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1.rsp_err",   32'(rsp_err),   32'h0);
    check("t1.rsp_data",  32'(rsp_data),  32'h0);
    check("t1.en_off",    32'(sram_en),   32'h0);
    check("t1.sel_off",   32'({sh_c8, sh_c4, sh_c2, sh_c1}), 32'h0);
    finish_rsp("t1");

    // 2: 4-bit read at offset 4, data only valid RD_LAT after the strobe
    sram_dout = 8'h00;
    drive_req(1'b0, 2'd2, 8'h21, 3'd4, 8'h00);
    tick();
    req_valid = 1'b0;
    check("t2.sram_en",    32'(sram_en),    32'h1);
    check("t2.sram_we",    32'(sram_we),    32'h0);
    check("t2.sram_wmask", 32'(sram_wmask), 32'h0);
    check("t2.sel",        32'({sh_c8, sh_c4, sh_c2, sh_c1}), 32'h4);
    check("t2.sram_addr",  32'(sram_addr),  32'h21);
    tick();
    sram_dout = 8'hA5;
    check("t2.wait_rsp_valid", 32'(rsp_valid), 32'h0);
    check("t2.wait_en",        32'(sram_en),   32'h0);
    tick();
    sram_dout = 8'hFF;
    check("t2.rsp_valid", 32'(rsp_valid), 32'h1);
    check("t2.rsp_data",  32'(rsp_data),  32'h0A);
    tick();
    check("t2.hold_data", 32'(rsp_data),  32'h0A);
    finish_rsp("t2");

    // 3: 2-bit read at offset 2 with response back-pressure
    drive_req(1'b0, 2'd1, 8'h40, 3'd2, 8'h00);
    tick();
    req_valid = 1'b0;
    tick();
    sram_dout = 8'b0000_1100;
    tick();
    sram_dout = 8'h00;
    drive_req(1'b1, 2'd3, 8'h41, 3'd0, 8'h55);
    for (int i = 0; i < 4; i++) begin
      check("t3.rsp_valid", 32'(rsp_valid), 32'h1);
      check("t3.rsp_data",  32'(rsp_data),  32'h03);
      check("t3.req_ready", 32'(req_ready), 32'h0);
      check("t3.sram_en",   32'(sram_en),   32'h0);
      tick();
    end
    req_valid = 1'b0;
    finish_rsp("t3");

    // 4: misaligned 4-bit write at offset 2
    drive_req(1'b1, 2'd2, 8'h33, 3'd2, 8'h0F);
    tick();
    req_valid = 1'b0;
`ifdef SRAM_ACC_ERR_EN
    check("t4.sram_en",   32'(sram_en),   32'h0);
    check("t4.rsp_valid", 32'(rsp_valid), 32'h1);
    check("t4.rsp_err",   32'(rsp_err),   32'h1);
    check("t4.rsp_data",  32'(rsp_data),  32'h0);
    finish_rsp("t4");
    check("t4.sram_en_after", 32'(sram_en), 32'h0);
`else
    check("t4.sram_en",    32'(sram_en),    32'h1);
    check("t4.sram_wmask", 32'(sram_wmask), 32'h0F);
    check("t4.sel",        32'({sh_c8, sh_c4, sh_c2, sh_c1}), 32'h4);
    tick();
    check("t4.rsp_valid", 32'(rsp_valid), 32'h1);
    check("t4.rsp_err",   32'(rsp_err),   32'h0);
    finish_rsp("t4");
`endif

    // 5: asynchronous reset during WAIT of a read
    drive_req(1'b0, 2'd0, 8'h77, 3'd3, 8'hAA);
    tick();
    req_valid = 1'b0;
    tick();
    sram_dout = 8'hFF;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("t5");
    tick();
    rst_n = 1'b1;
    tick();
    check("t5.req_ready", 32'(req_ready), 32'h1);
    check("t5.rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    check("t5.rsp_valid_late", 32'(rsp_valid), 32'h0);

    // 6: back-to-back full-word writes, one acceptance per three cycles
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_req(1'b1, 2'd3, 8'(8'h80 + i), 3'd5, 8'(i * 17));
      check("t6.req_ready", 32'(req_ready), 32'h1);
      tick();
      check("t6.sram_en",    32'(sram_en),    32'h1);
      check("t6.sram_wmask", 32'(sram_wmask), 32'hFF);
      check("t6.sel",        32'({sh_c8, sh_c4, sh_c2, sh_c1}), 32'h8);
      check("t6.sram_addr",  32'(sram_addr),  32'(8'h80 + i));
      check("t6.busy",       32'(req_ready),  32'h0);
      tick();
      check("t6.rsp_valid",  32'(rsp_valid),  32'h1);
      check("t6.busy_resp",  32'(req_ready),  32'h0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("t6.final_ready", 32'(req_ready), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
